// File: rtl/param_lock_fsm_if.sv
// param_lock_fsm_if: switch/key/tick inputs and 7-seg/LED outputs of the password lock.
// master = board side (drives inputs), slave = lock controller.
interface param_lock_fsm_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic                    tick;
    logic [DIGIT_W-1:0]      user_in;
    logic [NUM_DIGITS-1:0]   key_n;
    logic                    chg_req;
    logic [7*NUM_DIGITS-1:0] seg;
    logic                    led_pass;
    logic                    led_fail;
    logic                    led_lock;

    modport master (
        output tick, user_in, key_n, chg_req,
        input  seg, led_pass, led_fail, led_lock
    );

    modport slave (
        input  tick, user_in, key_n, chg_req,
        output seg, led_pass, led_fail, led_lock
    );
endinterface

// File: rtl/param_lock_fsm.sv
// param_lock_fsm: N-digit password lock with blinking digit entry, PASS/FAIL display,
// retry lockout and entry timeout. All timing is counted in external tick enables.
// Optional feature: define PW_CHANGE_EN to allow reprogramming the password from PASS.
module param_lock_fsm #(
    parameter int                              NUM_DIGITS    = 4,
    parameter int                              DIGIT_W       = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_PW    = 16'h01AF,
    parameter int                              MAX_TRIES     = 3,
    parameter int                              RESULT_TICKS  = 7,
    parameter int                              HOLD_TICKS    = 7,
    parameter int                              LOCKOUT_TICKS = 20,
    parameter int                              TIMEOUT_TICKS = 40
) (
    input  logic            clk_50,
    input  logic            rst,
    param_lock_fsm_if.slave bus
);
    localparam int PW_W   = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int MAX_A  = (RESULT_TICKS > HOLD_TICKS) ? RESULT_TICKS : HOLD_TICKS;
    localparam int MAX_B  = (LOCKOUT_TICKS > TIMEOUT_TICKS) ? LOCKOUT_TICKS : TIMEOUT_TICKS;
    localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENTRY  = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_PASS   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;
    localparam logic [2:0] ST_LOCK   = 3'd6;
`ifdef PW_CHANGE_EN
    localparam logic [2:0] ST_PROG   = 3'd7;
`endif

    logic [2:0]            state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [CNT_W-1:0]      tick_cnt;
    logic [2:0]            fail_cnt, fail_nxt;
    logic                  blink;
    logic [NUM_DIGITS-1:0] key_s1, key_s2, press, press_rev;
    logic [DIGIT_W-1:0]    digits_q [NUM_DIGITS];
    logic [PW_W-1:0]       entered, pw;
    logic                  in_entry, confirm;
    logic [7*NUM_DIGITS-1:0] seg_c;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // "PASS" / "FAIL" letters on digits 0..3, blank beyond
    function automatic logic [6:0] word7(input logic is_fail, input int unsigned pos);
        case (pos)
            0:       return is_fail ? 7'b0001110 : 7'b0001100;
            1:       return 7'b0001000;
            2:       return is_fail ? 7'b1111001 : 7'b0010010;
            3:       return is_fail ? 7'b1000111 : 7'b0010010;
            default: return SEG_BLANK;
        endcase
    endfunction

    // key synchroniser and falling-edge detector; a held key fires exactly once
    always_ff @(posedge clk_50) begin
        if (!rst) begin
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            key_s1 <= bus.key_n;
            key_s2 <= key_s1;
        end
    end

    assign press     = key_s2 & ~key_s1;
    assign press_rev = {<<{press}};   // digit i is confirmed by key_n[NUM_DIGITS-1-i]

`ifdef PW_CHANGE_EN
    assign in_entry = (state == ST_ENTRY) || (state == ST_PROG);
`else
    logic chg_req_unused;
    assign chg_req_unused = bus.chg_req;
    assign in_entry = (state == ST_ENTRY);
    assign pw       = DEFAULT_PW;
`endif
    assign confirm = in_entry & press_rev[idx];

    // pack confirmed digits with digit 0 in the MSBs to match the password layout
    always_comb begin
        entered = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            entered[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digits_q[i];
    end

    // next-state, digit index and retry counter
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        fail_nxt  = fail_cnt;
        case (state)
            ST_IDLE:
                if (bus.user_in != '0) begin
                    state_nxt = ST_ENTRY;
                    idx_nxt   = '0;
                end
            ST_ENTRY:
                if (confirm) begin
                    if (idx == LAST_IDX) state_nxt = ST_VERIFY;
                    else                 idx_nxt   = idx + IDX_W'(1);
                end else if (tick_cnt == CNT_W'(TIMEOUT_TICKS)) begin
                    state_nxt = ST_IDLE;
                end
`ifdef PW_CHANGE_EN
            ST_PROG:
                if (confirm) begin
                    if (idx == LAST_IDX) state_nxt = ST_HOLD;
                    else                 idx_nxt   = idx + IDX_W'(1);
                end
`endif
            ST_VERIFY:
                if (entered == pw) begin
                    state_nxt = ST_PASS;
                    fail_nxt  = '0;
                end else begin
                    fail_nxt  = fail_cnt + 3'd1;
                    state_nxt = (fail_cnt + 3'd1 == 3'(MAX_TRIES)) ? ST_LOCK : ST_FAIL;
                end
            ST_PASS:
`ifdef PW_CHANGE_EN
                if (bus.chg_req) begin
                    state_nxt = ST_PROG;
                    idx_nxt   = '0;
                end else
`endif
                if (tick_cnt == CNT_W'(RESULT_TICKS)) state_nxt = ST_HOLD;
            ST_FAIL:
                if (tick_cnt == CNT_W'(RESULT_TICKS)) state_nxt = ST_HOLD;
            ST_HOLD:
                if (tick_cnt == CNT_W'(HOLD_TICKS)) state_nxt = ST_IDLE;
            ST_LOCK:
                if (tick_cnt == CNT_W'(LOCKOUT_TICKS)) begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = '0;
                end
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // state registers, per-state tick counter, blink and digit/password storage
    always_ff @(posedge clk_50) begin
        if (!rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            tick_cnt <= '0;
            fail_cnt <= '0;
            blink    <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digits_q[i] <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            fail_cnt <= fail_nxt;
            if (bus.tick) blink <= ~blink;
            // a confirm restarts the timeout even when a tick lands in the same cycle
            if (state_nxt != state || confirm) tick_cnt <= '0;
            else if (bus.tick)                 tick_cnt <= tick_cnt + CNT_W'(1);
            if (confirm) digits_q[idx] <= bus.user_in;
        end
    end

`ifdef PW_CHANGE_EN
    // programmed password: last digit comes straight from the switches on the final confirm
    always_ff @(posedge clk_50) begin
        if (!rst)
            pw <= DEFAULT_PW;
        else if (state == ST_PROG && confirm && idx == LAST_IDX)
            pw <= {entered[PW_W-1:DIGIT_W], bus.user_in};
    end
`endif

    // seven-segment display composition
    always_comb begin
        seg_c = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (in_entry) begin
                if (32'(idx) > i)       seg_c[7*i +: 7] = hex7(4'(digits_q[i]));
                else if (32'(idx) == i) seg_c[7*i +: 7] = blink ? SEG_BLANK : hex7(4'(bus.user_in));
                else                    seg_c[7*i +: 7] = SEG_DASH;
            end else begin
                case (state)
                    ST_PASS: seg_c[7*i +: 7] = word7(1'b0, i);
                    ST_FAIL: seg_c[7*i +: 7] = word7(1'b1, i);
                    ST_HOLD: seg_c[7*i +: 7] = SEG_BLANK;
                    ST_LOCK: seg_c[7*i +: 7] = blink ? SEG_BLANK : SEG_DASH;
                    default: seg_c[7*i +: 7] = SEG_DASH;
                endcase
            end
        end
    end

    assign bus.seg      = seg_c;
    assign bus.led_pass = (state == ST_PASS);
    assign bus.led_fail = (state == ST_FAIL);
    assign bus.led_lock = (state == ST_LOCK);
endmodule

// File: tb/tb_param_lock_fsm.sv
// tb_param_lock_fsm: directed vectors for the password lock with hand-computed display/LED values.
// Define PW_CHANGE_EN for both files to include the password-programming sequence.
module tb_param_lock_fsm;
    localparam logic [6:0]  DASH     = 7'b0111111;
    localparam logic [6:0]  BLANK    = 7'b1111111;
    localparam logic [6:0]  H0       = 7'b1000000;
    localparam logic [6:0]  H1       = 7'b1111001;
    localparam logic [27:0] DASH4    = {DASH, DASH, DASH, DASH};
    localparam logic [27:0] BLANK4   = 28'hFFFFFFF;
    localparam logic [27:0] PASS_SEG = {7'b0010010, 7'b0010010, 7'b0001000, 7'b0001100};
    localparam logic [27:0] FAIL_SEG = {7'b1000111, 7'b1111001, 7'b0001000, 7'b0001110};

    logic       clk_50 = 1'b0;
    logic       rst    = 1'b0;
    logic       tb_blink = 1'b0;
    logic [6:0] t7;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk_50 = ~clk_50;

    param_lock_fsm_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

    param_lock_fsm #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DEFAULT_PW(16'h01AF), .MAX_TRIES(3),
        .RESULT_TICKS(7), .HOLD_TICKS(7), .LOCKOUT_TICKS(20), .TIMEOUT_TICKS(40)
    ) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] blk(input logic [6:0] v);
        return tb_blink ? BLANK : v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step(1);
        bus.tick = 1'b0;
        tb_blink = ~tb_blink;
        step(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic press(input int k);
        bus.key_n[k] = 1'b0;
        step(4);
        bus.key_n[k] = 1'b1;
        step(4);
    endtask

    task automatic enter_digits(input logic [15:0] code, input int first);
        for (int i = first; i < 4; i++) begin
            bus.user_in = code[(3-i)*4 +: 4];
            step(1);
            press(3 - i);
        end
        bus.user_in = 4'h0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        bus.user_in = 4'h1;
        step(2);
        enter_digits(code, 0);
    endtask

    function automatic logic [31:0] leds();
        return {29'd0, bus.led_pass, bus.led_fail, bus.led_lock};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.tick = 1'b0; bus.user_in = 4'h0; bus.key_n = 4'hF; bus.chg_req = 1'b0;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        tb_blink = 1'b0;
        check("rst_seg", bus.seg, DASH4);
        check("rst_leds", leds(), 32'd0);
        do_tick();
        check("idle_seg", bus.seg, DASH4);

        // correct password
        enter_code(16'h01AF);
        check("pass_seg", bus.seg, PASS_SEG);
        check("pass_leds", leds(), 32'd4);
        ticks(6);
        check("pass_6t", leds(), 32'd4);
        do_tick();
        check("hold_seg", bus.seg, BLANK4);
        check("hold_leds", leds(), 32'd0);
        ticks(6);
        check("hold_6t", bus.seg, BLANK4);
        do_tick();
        check("idle_after_pass", bus.seg, DASH4);

        // wrong key ignored, held key confirms once
        bus.user_in = 4'h1;
        step(2);
        bus.user_in = 4'h0;
        press(0);
        check("wrong_key", bus.seg, {DASH, DASH, DASH, blk(H0)});
        bus.key_n[3] = 1'b0;
        step(4);
        bus.user_in = 4'h1;
        ticks(10);
        check("held_key", bus.seg, {DASH, DASH, blk(H1), H0});
        bus.key_n[3] = 1'b1;
        step(4);
        enter_digits(16'h01AE, 1);
        check("fail_seg", bus.seg, FAIL_SEG);
        check("fail_leds", leds(), 32'd2);
        ticks(7);
        check("fail_hold", bus.seg, BLANK4);
        ticks(7);
        check("fail_idle", bus.seg, DASH4);

        // entry timeout leaves the retry count alone
        bus.user_in = 4'h1;
        step(2);
        bus.user_in = 4'h0;
        press(3);
        ticks(39);
        check("to_39t", bus.seg, {DASH, DASH, blk(H0), H0});
        do_tick();
        check("to_seg", bus.seg, DASH4);
        check("to_leds", leds(), 32'd0);

        enter_code(16'h01AE);
        check("fail2_leds", leds(), 32'd2);
        ticks(14);
        check("fail2_idle", bus.seg, DASH4);

        // third consecutive failure locks out
        enter_code(16'h01AE);
        check("lock_leds", leds(), 32'd1);
        t7 = blk(DASH);
        check("lock_seg", bus.seg, {t7, t7, t7, t7});
        bus.user_in = 4'h5;
        press(3);
        bus.user_in = 4'h0;
        check("lock_keys", leds(), 32'd1);
        ticks(19);
        check("lock_19t", leds(), 32'd1);
        do_tick();
        check("unlock_leds", leds(), 32'd0);
        check("unlock_seg", bus.seg, DASH4);

        // retry count cleared by lockout; reset mid-FAIL
        enter_code(16'h01AE);
        check("fail_post_lock", leds(), 32'd2);
        rst = 1'b0;
        step(1);
        check("rst_mid_seg", bus.seg, DASH4);
        check("rst_mid_leds", leds(), 32'd0);
        rst = 1'b1;
        tb_blink = 1'b0;
        step(1);
        enter_code(16'h01AF);
        check("pass_post_rst", leds(), 32'd4);

`ifdef PW_CHANGE_EN
        bus.chg_req = 1'b1;
        step(2);
        bus.chg_req = 1'b0;
        enter_digits(16'h1234, 0);
        check("prog_hold", bus.seg, BLANK4);
        ticks(7);
        enter_code(16'h1234);
        check("new_pw_pass", leds(), 32'd4);
        ticks(14);
        enter_code(16'h01AF);
        check("old_pw_fail", leds(), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
